// File: rtl/beta_pkg.sv
// Shared encodings for the debug register-access port: command opcodes and FSM states.
package beta_pkg;

  typedef enum logic [1:0] {
    OP_READ  = 2'b00,
    OP_WRITE = 2'b01,
    OP_DUMP  = 2'b10,
    OP_RSVD  = 2'b11
  } dbg_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RSP  = 2'b01,
    ST_DUMP = 2'b10
  } dbg_state_t;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;
  localparam int RF_AW  = 6;

  // R31 is hardwired to zero in the register file, so writes to it are refused.
  localparam logic [ADDR_W-1:0] RO_IDX = 5'd31;

endpackage

// File: rtl/reg_dbg_if.sv
// Command/response channel of the debug port; master is the debugger, slave is reg_dbg.
interface reg_dbg_if;
  import beta_pkg::*;

  logic              cmd_valid;
  logic              cmd_ready;
  dbg_op_t           cmd_op;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_data;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [ADDR_W-1:0] rsp_addr;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_last;
  logic              rsp_err;

  modport master (
    output cmd_valid, cmd_op, cmd_addr, cmd_data, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_addr, rsp_data, rsp_last, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_addr, cmd_data, rsp_ready,
    output cmd_ready, rsp_valid, rsp_addr, rsp_data, rsp_last, rsp_err
  );

endinterface

// File: rtl/reg_dbg.sv
// Debug access to the CPU register file while halted: single read/write and full dump.
// state | meaning
// IDLE  | waiting for a command (accepted only while halted)
// RSP   | single response held until rsp_ready
// DUMP  | streaming register[index] for index 0..NREGS-1
module reg_dbg
  import beta_pkg::*;
#(
  parameter int NREGS = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              halted,
  reg_dbg_if.slave          bus,
  output logic [RF_AW-1:0]  rf_ra,
  input  logic [DATA_W-1:0] rf_rd,
  output logic              rf_we,
  output logic [RF_AW-1:0]  rf_wa,
  output logic [DATA_W-1:0] rf_wd
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NREGS - 1);

  dbg_state_t        state;
  logic [ADDR_W-1:0] idx;
  logic              rsp_valid;
  logic [ADDR_W-1:0] rsp_addr;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_last;
  logic              rsp_err;

  logic cmd_ready;
  logic accept;
  logic wr_ok;

  assign cmd_ready = rst_n && halted && (state == ST_IDLE);
  assign accept    = bus.cmd_valid && cmd_ready;
  assign wr_ok     = accept && (bus.cmd_op == OP_WRITE) && (bus.cmd_addr != RO_IDX);

  assign bus.cmd_ready = cmd_ready;
  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_addr  = rsp_addr;
  assign bus.rsp_data  = rsp_data;
  assign bus.rsp_last  = rsp_last;
  assign bus.rsp_err   = rsp_err;

  // Write port is live only in the accepting cycle; the register file commits on that edge.
  assign rf_we = wr_ok;
  assign rf_wa = wr_ok ? {1'b0, bus.cmd_addr} : '0;
  assign rf_wd = wr_ok ? bus.cmd_data : '0;

  always_comb begin
    rf_ra = '0;
    if (accept && (bus.cmd_op == OP_READ)) begin
      rf_ra = {1'b0, bus.cmd_addr};
    end else if (rst_n && (state == ST_DUMP)) begin
      rf_ra = {1'b0, idx};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      idx       <= '0;
      rsp_valid <= 1'b0;
      rsp_addr  <= '0;
      rsp_data  <= '0;
      rsp_last  <= 1'b0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            rsp_addr <= bus.cmd_addr;
            rsp_last <= 1'b1;
            case (bus.cmd_op)
              OP_READ: begin
                rsp_valid <= 1'b1;
                rsp_data  <= rf_rd;
                rsp_err   <= 1'b0;
                state     <= ST_RSP;
              end
              OP_WRITE: begin
                rsp_valid <= 1'b1;
                rsp_data  <= bus.cmd_data;
                rsp_err   <= (bus.cmd_addr == RO_IDX);
                state     <= ST_RSP;
              end
              OP_DUMP: begin
                rsp_valid <= 1'b0;
                idx       <= '0;
                state     <= ST_DUMP;
              end
              default: begin
                rsp_valid <= 1'b1;
                rsp_data  <= '0;
                rsp_err   <= 1'b1;
                state     <= ST_RSP;
              end
            endcase
          end
        end
        ST_RSP: begin
          if (bus.rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        ST_DUMP: begin
          // One bubble per beat: capture when idle, then hold until the handshake.
          if (!rsp_valid) begin
            rsp_valid <= 1'b1;
            rsp_addr  <= idx;
            rsp_data  <= rf_rd;
            rsp_last  <= (idx == LAST_IDX);
            rsp_err   <= 1'b0;
          end else if (bus.rsp_ready) begin
            rsp_valid <= 1'b0;
            if (rsp_last) begin
              state <= ST_IDLE;
            end else begin
              idx <= idx + 5'd1;
            end
          end
        end
        default: begin
          state     <= ST_IDLE;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_dbg.sv
// Scoreboard bench for reg_dbg: directed commands push expected responses, a monitor pops on handshake.
module tb_reg_dbg;
  import beta_pkg::*;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
    logic        last;
    logic        err;
  } rsp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        halted = 1'b1;
  logic [5:0]  rf_ra;
  logic [31:0] rf_rd;
  logic        rf_we;
  logic [5:0]  rf_wa;
  logic [31:0] rf_wd;
  logic [31:0] mem [64];

  reg_dbg_if dif ();

  reg_dbg #(.NREGS(32)) dut (
    .clk(clk), .rst_n(rst_n), .halted(halted), .bus(dif),
    .rf_ra(rf_ra), .rf_rd(rf_rd), .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd)
  );

  always #5 clk = ~clk;

  assign rf_rd = mem[rf_ra];
  always @(posedge clk) if (rf_we) mem[rf_wa] <= rf_wd;

  int   n_total = 0;
  int   n_pass  = 0;
  int   hs_count = 0;
  int   we_count = 0;
  int   rdy_mode = 1;
  rsp_t sb[$];
  logic [5:0]  exp_wa;
  logic [31:0] exp_wd;

  task automatic chk(input string name, input logic ok, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // rsp_ready driver: mode 0 leaves it to the main thread, 1 holds high, 2 toggles.
  always @(posedge clk) begin
    #1;
    if (rdy_mode == 1) dif.rsp_ready = 1'b1;
    else if (rdy_mode == 2) dif.rsp_ready = ~dif.rsp_ready;
  end

  rsp_t held;
  logic prev_stall = 1'b0;

  always @(negedge clk) begin
    rsp_t act, e;
    act = '{dif.rsp_addr, dif.rsp_data, dif.rsp_last, dif.rsp_err};
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (rf_we) begin
        we_count++;
        chk("rf_wa", rf_wa == exp_wa, 64'(rf_wa), 64'(exp_wa));
        chk("rf_wd", rf_wd == exp_wd, 64'(rf_wd), 64'(exp_wd));
      end
      if (prev_stall)
        chk("stall_hold", dif.rsp_valid && (act == held), {dif.rsp_valid, 26'(0), act}, {1'b1, 26'(0), held});
      if (dif.rsp_valid && dif.rsp_ready) begin
        hs_count++;
        if (sb.size() == 0) begin
          chk("unexpected_rsp", 1'b0, 64'(act), 64'(0));
        end else begin
          e = sb.pop_front();
          chk("rsp", act == e, 64'(act), 64'(e));
        end
      end
      prev_stall = dif.rsp_valid && !dif.rsp_ready;
      held = act;
    end
  end

  task automatic send(input dbg_op_t op, input logic [4:0] addr, input logic [31:0] data);
    int cnt = 0;
    @(posedge clk); #3;
    dif.cmd_valid = 1'b1; dif.cmd_op = op; dif.cmd_addr = addr; dif.cmd_data = data;
    @(negedge clk);
    while (!dif.cmd_ready && cnt < 200) begin @(negedge clk); cnt++; end
    if (cnt >= 200) chk("cmd_accept_timeout", 1'b0, 64'(0), 64'(1));
    @(posedge clk); #3;
    dif.cmd_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int cnt = 0;
    while ((sb.size() != 0 || dif.rsp_valid) && cnt < 2000) begin @(negedge clk); cnt++; end
    chk(name, sb.size() == 0 && !dif.rsp_valid, 64'(sb.size()), 64'(0));
  endtask

  task automatic push_dump();
    for (int i = 0; i < 32; i++) sb.push_back('{5'(i), 32'(i * 3), i == 31, 1'b0});
  endtask

  task automatic wait_hs(input int target);
    int cnt = 0;
    while (hs_count < target && cnt < 2000) begin @(posedge clk); cnt++; end
    if (cnt >= 2000) chk("hs_timeout", 1'b0, 64'(hs_count), 64'(target));
    #2;
  endtask

  initial begin
    int we0, hs0;
    logic saw_ready;
    for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
    dif.cmd_valid = 1'b0; dif.cmd_op = OP_READ; dif.cmd_addr = '0; dif.cmd_data = '0;
    dif.rsp_ready = 1'b1;

    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", !dif.cmd_ready, 64'(dif.cmd_ready), 64'(0));
    chk("rst_rf", !rf_we && rf_ra == 0 && rf_wa == 0 && rf_wd == 0, {rf_we, rf_ra, rf_wa, rf_wd}, 64'(0));
    chk("rst_rsp", {dif.rsp_valid, dif.rsp_addr, dif.rsp_data, dif.rsp_last, dif.rsp_err} == '0,
        64'({dif.rsp_valid, dif.rsp_addr, dif.rsp_data, dif.rsp_last, dif.rsp_err}), 64'(0));
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_cmd_ready", dif.cmd_ready, 64'(dif.cmd_ready), 64'(1));

    // write then read back
    we0 = we_count; exp_wa = 6'd5; exp_wd = 32'hDEADBEEF;
    sb.push_back('{5'd5, 32'hDEADBEEF, 1'b1, 1'b0});
    send(OP_WRITE, 5'd5, 32'hDEADBEEF);
    drain("wr5_drain");
    chk("wr5_we_count", we_count - we0 == 1, 64'(we_count - we0), 64'(1));
    chk("wr5_mem", mem[5] == 32'hDEADBEEF, 64'(mem[5]), 64'hDEADBEEF);
    sb.push_back('{5'd5, 32'hDEADBEEF, 1'b1, 1'b0});
    send(OP_READ, 5'd5, 32'h0);
    drain("rd5_drain");

    // write to R31 refused, read unchanged
    we0 = we_count;
    sb.push_back('{5'd31, 32'h1, 1'b1, 1'b1});
    send(OP_WRITE, 5'd31, 32'h1);
    sb.push_back('{5'd31, 32'h0, 1'b1, 1'b0});
    send(OP_READ, 5'd31, 32'h0);
    drain("r31_drain");
    chk("r31_no_we", we_count == we0, 64'(we_count - we0), 64'(0));

    // reserved op
    sb.push_back('{5'd7, 32'h0, 1'b1, 1'b1});
    send(OP_RSVD, 5'd7, 32'h1234);
    drain("rsvd_drain");

    // not halted: command must not be accepted
    hs0 = hs_count; saw_ready = 1'b0;
    halted = 1'b0;
    @(posedge clk); #3;
    dif.cmd_valid = 1'b1; dif.cmd_op = OP_READ; dif.cmd_addr = 5'd5;
    repeat (10) begin @(negedge clk); if (dif.cmd_ready || dif.rsp_valid) saw_ready = 1'b1; end
    dif.cmd_valid = 1'b0;
    chk("nohalt_ready", !saw_ready, 64'(saw_ready), 64'(0));
    chk("nohalt_rsp", hs_count == hs0, 64'(hs_count), 64'(hs0));
    halted = 1'b1;

    // dump with toggling rsp_ready
    for (int i = 0; i < 64; i++) mem[i] <= (i < 32) ? 32'(i * 3) : 32'h0;
    we0 = we_count; hs0 = hs_count;
    rdy_mode = 2;
    push_dump();
    send(OP_DUMP, 5'd0, 32'h0);
    drain("dump_drain");
    chk("dump_beats", hs_count - hs0 == 32, 64'(hs_count - hs0), 64'(32));
    chk("dump_no_we", we_count == we0, 64'(we_count - we0), 64'(0));

    // halted drops mid-dump; dump completes
    rdy_mode = 1; hs0 = hs_count;
    push_dump();
    send(OP_DUMP, 5'd0, 32'h0);
    wait_hs(hs0 + 5);
    halted = 1'b0;
    @(negedge clk);
    chk("dump_nohalt_ready", !dif.cmd_ready, 64'(dif.cmd_ready), 64'(0));
    drain("dump_nohalt_drain");
    chk("dump_nohalt_beats", hs_count - hs0 == 32, 64'(hs_count - hs0), 64'(32));
    @(negedge clk);
    chk("after_dump_nohalt_ready", !dif.cmd_ready, 64'(dif.cmd_ready), 64'(0));
    halted = 1'b1;

    // reset at beat 10 of a dump
    rdy_mode = 2; hs0 = hs_count;
    push_dump();
    send(OP_DUMP, 5'd0, 32'h0);
    wait_hs(hs0 + 11);
    rdy_mode = 0; dif.rsp_ready = 1'b0; rst_n = 1'b0;
    @(posedge clk); #2;
    sb.delete();
    chk("midrst_valid", !dif.rsp_valid, 64'(dif.rsp_valid), 64'(0));
    chk("midrst_ra", rf_ra == 0 && !dif.cmd_ready, {dif.cmd_ready, rf_ra}, 64'(0));
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_idle", dif.cmd_ready && !dif.rsp_valid, {dif.cmd_ready, dif.rsp_valid}, 64'b10);
    rdy_mode = 1; dif.rsp_ready = 1'b1;
    sb.push_back('{5'd2, 32'd6, 1'b1, 1'b0});
    send(OP_READ, 5'd2, 32'h0);
    drain("post_rst_read_drain");

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
